ws2812_encoder: RTL

Serial transmitter for the NeoPixel (WS2812-class) one-wire LED protocol. It accepts 24-bit pixel words over a valid/ready handshake and shifts them out MSB-first as fixed-period, duty-coded pulses. After the last pixel of a frame it holds the line low for the latch (reset) interval. It is the driving end of the line whose edges the codebase's edge detector recovers. In the design it sits between the pixel frame buffer/FIFO and the LED data output pin.

---
 rtl/ws2812_encoder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ws2812_encoder.sv
// One-wire NeoPixel serial encoder: takes 24-bit pixel words on valid/ready and
// emits MSB-first duty-coded bit periods, then the latch low interval.
module ws2812_encoder #(
    parameter int unsigned T0H_CNT = 20,
    parameter int unsigned T1H_CNT = 40,
    parameter int unsigned BIT_CNT = 63,
    parameter int unsigned RST_CNT = 2500
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] data_i,
    input  logic        data_last_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic        dout_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        underrun_o
);

    localparam int unsigned PIX_W   = 24;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned CNT_MAX = (BIT_CNT > RST_CNT) ? BIT_CNT : RST_CNT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [PIX_W-1:0]   sr_q,       sr_d;
    logic               last_q,     last_d;
    logic [IDX_W-1:0]   bit_idx_q,  bit_idx_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               dout_q,     dout_d;
    logic               busy_q,     busy_d;
    logic               ready_q,    ready_d;
    logic               done_q,     done_d;
    logic               underrun_q, underrun_d;

    logic               xfer;
    logic               bit_end;
    logic               word_end;

    // Ready is held registered but must drop the moment reset is asserted.
    assign data_ready_o = ready_q & ~rst_i;
    assign dout_o       = dout_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign underrun_o   = underrun_q;

    assign xfer     = data_valid_i & data_ready_o;
    assign bit_end  = (cnt_q == CNT_W'(BIT_CNT - 1));
    assign word_end = bit_end && (bit_idx_q == IDX_W'(PIX_W - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            last_q     <= 1'b0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            last_q     <= last_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state logic; registered outputs are derived from the next-state values
    // so each output register describes the cycle the state registers describe.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        last_d     = last_q;
        bit_idx_d  = bit_idx_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d   = SHIFT;
                    sr_d      = data_i;
                    last_d    = data_last_i;
                    bit_idx_d = '0;
                    cnt_d     = '0;
                end
            end
            SHIFT: begin
                if (!bit_end) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!word_end) begin
                    cnt_d     = '0;
                    sr_d      = {sr_q[PIX_W-2:0], 1'b0};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end else if (last_q) begin
                    state_d   = LATCH;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else if (xfer) begin
                    sr_d      = data_i;
                    last_d    = data_last_i;
                    bit_idx_d = '0;
                    cnt_d     = '0;
                end else begin
                    state_d    = LATCH;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    underrun_d = 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == CNT_W'(RST_CNT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        dout_d  = (state_d == SHIFT) &&
                  (cnt_d < (sr_d[PIX_W-1] ? CNT_W'(T1H_CNT) : CNT_W'(T0H_CNT)));
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) ||
                  ((state_d == SHIFT) && (cnt_d == CNT_W'(BIT_CNT - 1)) &&
                   (bit_idx_d == IDX_W'(PIX_W - 1)) && !last_d);
    end

endmodule
